// File: rtl/trigger_delay_pkg.sv
// Shared types and register map for the multi-channel trigger delay block.
package trigger_delay_pkg;

    // Edge selection encoding held in CTRL[1:0]
    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_t;

    // Per-channel register offsets (low three address bits)
    localparam logic [2:0] REG_DELAY   = 3'd0;
    localparam logic [2:0] REG_WIDTH   = 3'd1;
    localparam logic [2:0] REG_CTRL    = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_LAST_TS = 3'd4;

    // CTRL bit positions
    localparam int CTRL_EDGE_LSB  = 0;
    localparam int CTRL_EDGE_MSB  = 1;
    localparam int CTRL_ENABLE    = 2;
    localparam int CTRL_CLR_COUNT = 3;
    localparam int CTRL_CLR_OVF   = 4;

    // STATUS field positions
    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_COUNT_MSB = 15;
    localparam int STAT_OVF       = 16;
    localparam int STAT_OCC_LSB   = 20;
    localparam int STAT_OCC_MSB   = 23;

    // Edge detector for the selected edge type
    function automatic logic edge_hit(input edge_t sel, input logic cur, input logic prev);
        logic hit;
        case (sel)
            EDGE_RISE: hit = cur & ~prev;
            EDGE_FALL: hit = ~cur & prev;
            EDGE_BOTH: hit = cur ^ prev;
            EDGE_NONE: hit = 1'b0;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/trigger_delay_channel.sv
// One trigger delay channel: input synchroniser, edge detect, pending-target
// queue, pulse generator and the channel's register file.
// Optional build macro: TRIG_DELAY_TIMESTAMP_EN adds the LAST_TS register.
// DELAY_W must not exceed 32 (registers are loaded from the 32-bit write bus).
module trigger_delay_channel
    import trigger_delay_pkg::*;
#(
    parameter int DELAY_W     = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int SYNC_STAGES = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_trig,
    input  logic               i_soft,
    input  logic [DELAY_W-1:0] i_timebase,
    input  logic               i_we,
    input  logic [2:0]         i_reg,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_trig,
    output logic               o_ovf
);

    localparam int                 PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [DELAY_W-1:0] ONE   = DELAY_W'(1);
    localparam logic [PTR_W:0]     DEPTH = (PTR_W+1)'(QUEUE_DEPTH);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic [DELAY_W-1:0]     r_delay;
    logic [DELAY_W-1:0]     r_width;
    edge_t                  r_edge;
    logic                   r_enable;
    logic [15:0]            r_count;
    logic                   r_ovf;
    logic [DELAY_W-1:0]     r_queue [QUEUE_DEPTH];
    logic [PTR_W:0]         r_rd_ptr;
    logic [PTR_W:0]         r_wr_ptr;
    logic                   r_trig;
    logic [DELAY_W-1:0]     r_width_cnt;

    logic [DELAY_W-1:0] w_tb_next;
    logic [DELAY_W-1:0] w_target;
    logic [DELAY_W-1:0] w_eff_width;
    logic [PTR_W:0]     w_occ;
    logic               w_empty;
    logic               w_full;
    logic               w_wr_delay;
    logic               w_wr_width;
    logic               w_wr_ctrl;
    logic               w_ep;
    logic               w_accept;
    logic               w_bypass;
    logic               w_push_req;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_fire;

    // trig_out is registered, so the fire decision is taken one cycle ahead by
    // comparing the queue head against next cycle's timebase. A zero delay
    // cannot go through the queue at all and fires straight from the edge.
    assign w_tb_next   = i_timebase + ONE;
    assign w_target    = i_timebase + r_delay + ONE;
    assign w_eff_width = (r_width == '0) ? ONE : r_width;
    assign w_occ       = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (w_occ == '0);
    assign w_full      = (w_occ == DEPTH);
    assign w_wr_delay  = i_we && (i_reg == REG_DELAY);
    assign w_wr_width  = i_we && (i_reg == REG_WIDTH);
    assign w_wr_ctrl   = i_we && (i_reg == REG_CTRL);
    assign w_ep        = edge_hit(r_edge, r_sync[SYNC_STAGES-1], r_sync_d) | i_soft;
    // An edge coinciding with a DELAY write is discarded along with the flush
    assign w_accept    = w_ep & r_enable & ~w_wr_delay;
    assign w_bypass    = w_accept & (r_delay == '0);
    assign w_push_req  = w_accept & (r_delay != '0);
    assign w_pop       = ~w_empty && (r_queue[r_rd_ptr[PTR_W-1:0]] == w_tb_next);
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_drop      = w_push_req & w_full & ~w_pop;
    assign w_fire      = w_pop | w_bypass;
    assign o_trig      = r_trig;
    assign o_ovf       = r_ovf;

    // Input synchroniser plus one delayed copy for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_trig};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    // Configuration registers, edge counter and sticky overflow flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_delay  <= '0;
            r_width  <= ONE;
            r_edge   <= EDGE_RISE;
            r_enable <= 1'b1;
            r_count  <= 16'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_delay) begin
                r_delay <= i_wdata[DELAY_W-1:0];
            end
            if (w_wr_width) begin
                r_width <= i_wdata[DELAY_W-1:0];
            end
            if (w_wr_ctrl) begin
                r_edge   <= edge_t'(i_wdata[CTRL_EDGE_MSB:CTRL_EDGE_LSB]);
                r_enable <= i_wdata[CTRL_ENABLE];
            end
            if (w_wr_ctrl && i_wdata[CTRL_CLR_COUNT]) begin
                r_count <= 16'd0;
            end else if (w_ep) begin
                r_count <= r_count + 16'd1;
            end
            if (w_wr_ctrl && i_wdata[CTRL_CLR_OVF]) begin
                r_ovf <= 1'b0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Pending-target queue; a DELAY write empties it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_queue[i] <= '0;
            end
        end else if (w_wr_delay) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_queue[r_wr_ptr[PTR_W-1:0]] <= w_target;
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Pulse generator; a fire during an active pulse reloads the width counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_trig      <= 1'b0;
            r_width_cnt <= '0;
        end else if (w_fire) begin
            r_trig      <= 1'b1;
            r_width_cnt <= w_eff_width - ONE;
        end else if (r_trig) begin
            if (r_width_cnt == '0) begin
                r_trig <= 1'b0;
            end else begin
                r_width_cnt <= r_width_cnt - ONE;
            end
        end
    end

`ifdef TRIG_DELAY_TIMESTAMP_EN
    logic [DELAY_W-1:0] r_last_ts;

    // Timebase of the cycle in which the most recent pulse starts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_ts <= '0;
        end else if (w_fire) begin
            r_last_ts <= w_tb_next;
        end
    end
`endif

    // Register readback for the addressed offset
    always_comb begin
        o_rdata = 32'd0;
        case (i_reg)
            REG_DELAY:  o_rdata = 32'(r_delay);
            REG_WIDTH:  o_rdata = 32'(r_width);
            REG_CTRL: begin
                o_rdata[CTRL_EDGE_MSB:CTRL_EDGE_LSB] = r_edge;
                o_rdata[CTRL_ENABLE]                 = r_enable;
            end
            REG_STATUS: begin
                o_rdata[STAT_COUNT_MSB:STAT_COUNT_LSB] = r_count;
                o_rdata[STAT_OVF]                      = r_ovf;
                o_rdata[STAT_OCC_MSB:STAT_OCC_LSB]     = 4'(w_occ);
            end
`ifdef TRIG_DELAY_TIMESTAMP_EN
            REG_LAST_TS: o_rdata = 32'(r_last_ts);
`endif
            default:    o_rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/trigger_delay_mc.sv
// Multi-channel trigger delay: shared timebase, register address decode and
// registered read mux around NUM_CH independent channels.
// Optional build macro: TRIG_DELAY_TIMESTAMP_EN (per-channel LAST_TS at reg 4).
module trigger_delay_mc
    import trigger_delay_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DELAY_W     = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int SYNC_STAGES = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           trig_in,
    input  logic [NUM_CH-1:0]           soft_trig,
    output logic [NUM_CH-1:0]           trig_out,
    input  logic                        cfg_we,
    input  logic                        cfg_re,
    input  logic [$clog2(NUM_CH)+2:0]   cfg_addr,
    input  logic [31:0]                 cfg_wdata,
    output logic [31:0]                 cfg_rdata,
    output logic                        cfg_rvalid,
    output logic [NUM_CH-1:0]           ovf
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DELAY_W-1:0] r_timebase;
    logic [31:0]        r_rdata;
    logic               r_rvalid;

    logic [CH_W-1:0]    w_ch;
    logic               w_ch_ok;
    logic [NUM_CH-1:0]  w_we;
    logic [31:0]        w_ch_rdata [NUM_CH];
    logic [31:0]        w_rd_mux;

    generate
        if (NUM_CH > 1) begin : g_multi
            assign w_ch = cfg_addr[$clog2(NUM_CH)+2:3];
        end else begin : g_single
            assign w_ch = 1'b0;
        end
    endgenerate

    assign w_ch_ok    = (32'(w_ch) < 32'(NUM_CH));
    assign cfg_rdata  = r_rdata;
    assign cfg_rvalid = r_rvalid;

    // Free-running timebase shared by all channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timebase <= '0;
        end else begin
            r_timebase <= r_timebase + DELAY_W'(1);
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
            assign w_we[g] = cfg_we & w_ch_ok & (w_ch == CH_W'(g));

            trigger_delay_channel #(
                .DELAY_W     (DELAY_W),
                .QUEUE_DEPTH (QUEUE_DEPTH),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_chan (
                .i_clk      (clk),
                .i_rst_n    (rst_n),
                .i_trig     (trig_in[g]),
                .i_soft     (soft_trig[g]),
                .i_timebase (r_timebase),
                .i_we       (w_we[g]),
                .i_reg      (cfg_addr[2:0]),
                .i_wdata    (cfg_wdata),
                .o_rdata    (w_ch_rdata[g]),
                .o_trig     (trig_out[g]),
                .o_ovf      (ovf[g])
            );
        end
    endgenerate

    // Select the addressed channel's readback; absent channels read zero
    always_comb begin
        w_rd_mux = 32'd0;
        if (w_ch_ok) begin
            w_rd_mux = w_ch_rdata[w_ch];
        end else begin
            w_rd_mux = 32'd0;
        end
    end

    // Registered read port: data captured on the strobe, valid one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= 32'd0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= cfg_re;
            if (cfg_re) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_trigger_delay_mc.sv
// Directed bench for trigger_delay_mc: a register-access vector table plus
// hand-timed sequences for delay, queueing, merging, flush and reset.
module tb_trigger_delay_mc;
    import trigger_delay_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  trig_in;
    logic [3:0]  soft_trig;
    logic [3:0]  trig_out;
    logic        cfg_we;
    logic        cfg_re;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cfg_rvalid;
    logic [3:0]  ovf;

    int n_cmp;
    int n_bad;
    int tb_cycle;

    trigger_delay_mc #(
        .NUM_CH(4), .DELAY_W(32), .QUEUE_DEPTH(4), .SYNC_STAGES(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig_in    (trig_in),
        .soft_trig  (soft_trig),
        .trig_out   (trig_out),
        .cfg_we     (cfg_we),
        .cfg_re     (cfg_re),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .cfg_rvalid (cfg_rvalid),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  ch;
        logic [2:0]  rg;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance n clock cycles; inputs and outputs are handled 1 time unit after the edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tb_cycle++;
        end
    endtask

    task automatic cfg_write(input int ch, input logic [2:0] rg, input logic [31:0] d);
        cfg_addr  = {2'(ch), rg};
        cfg_wdata = d;
        cfg_we    = 1'b1;
        tick(1);
        cfg_we    = 1'b0;
    endtask

    task automatic cfg_read(input int ch, input logic [2:0] rg, output logic [31:0] d);
        cfg_addr = {2'(ch), rg};
        cfg_re   = 1'b1;
        tick(1);
        cfg_re   = 1'b0;
        check("rvalid", 32'(cfg_rvalid), 32'd1);
        d = cfg_rdata;
    endtask

    logic [31:0] rd;
    int          ts0;
    logic        exp_bit;

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        tb_cycle  = 0;
        rst_n     = 1'b0;
        trig_in   = 4'd0;
        soft_trig = 4'd0;
        cfg_we    = 1'b0;
        cfg_re    = 1'b0;
        cfg_addr  = 5'd0;
        cfg_wdata = 32'd0;

        // ---------------- reset state ----------------
        tick(3);
        check("rst_trig_out", 32'(trig_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_rdata", cfg_rdata, 32'd0);
        check("rst_rvalid", 32'(cfg_rvalid), 32'd0);
        rst_n    = 1'b1;
        tb_cycle = 0;
        tick(2);

        // ---------------- register access table ----------------
        vecs[0]  = '{1'b0, 1'b1, 2'd0, REG_DELAY,   32'd0,          32'd0};
        vecs[1]  = '{1'b0, 1'b1, 2'd0, REG_WIDTH,   32'd0,          32'd1};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, REG_CTRL,    32'd0,          32'h4};
        vecs[3]  = '{1'b0, 1'b1, 2'd0, REG_STATUS,  32'd0,          32'd0};
        vecs[4]  = '{1'b0, 1'b1, 2'd0, REG_LAST_TS, 32'd0,          32'd0};
        vecs[5]  = '{1'b1, 1'b0, 2'd1, REG_DELAY,   32'h0000_1234,  32'd0};
        vecs[6]  = '{1'b0, 1'b1, 2'd1, REG_DELAY,   32'd0,          32'h0000_1234};
        vecs[7]  = '{1'b0, 1'b1, 2'd0, REG_DELAY,   32'd0,          32'd0};
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 3'd5,        32'hDEAD_BEEF,  32'd0};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 3'd5,        32'd0,          32'd0};
        vecs[10] = '{1'b1, 1'b0, 2'd3, REG_CTRL,    32'h0000_001B,  32'd0};
        vecs[11] = '{1'b0, 1'b1, 2'd3, REG_CTRL,    32'd0,          32'h3};
        vecs[12] = '{1'b1, 1'b1, 2'd1, REG_DELAY,   32'h0000_0055,  32'h0000_1234};
        vecs[13] = '{1'b0, 1'b1, 2'd1, REG_DELAY,   32'd0,          32'h0000_0055};
        vecs[14] = '{1'b1, 1'b0, 2'd3, REG_CTRL,    32'h0000_0004,  32'd0};
        vecs[15] = '{1'b1, 1'b0, 2'd1, REG_DELAY,   32'd0,          32'd0};
        vecs[16] = '{1'b0, 1'b1, 2'd3, REG_CTRL,    32'd0,          32'h4};
        vecs[17] = '{1'b1, 1'b0, 2'd2, REG_WIDTH,   32'd9,          32'd0};
        vecs[18] = '{1'b0, 1'b1, 2'd2, REG_WIDTH,   32'd0,          32'd9};
        vecs[19] = '{1'b1, 1'b0, 2'd2, REG_WIDTH,   32'd1,          32'd0};

        for (int v = 0; v < 20; v++) begin
            cfg_we    = vecs[v].we;
            cfg_re    = vecs[v].re;
            cfg_addr  = {vecs[v].ch, vecs[v].rg};
            cfg_wdata = vecs[v].wdata;
            tick(1);
            cfg_we = 1'b0;
            cfg_re = 1'b0;
            if (vecs[v].re) begin
                check($sformatf("vec%0d_rdata", v), cfg_rdata, vecs[v].exp);
                check($sformatf("vec%0d_rvalid", v), 32'(cfg_rvalid), 32'd1);
            end
        end

        // ---------------- 1: DELAY=10 WIDTH=3 via synchronised rising edge ----------------
        // Edge is seen 3 cycles after the input changes, pulse occupies t+11..t+13.
        cfg_write(0, REG_DELAY, 32'd10);
        cfg_write(0, REG_WIDTH, 32'd3);
        trig_in[0] = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            check($sformatf("basic_k%0d", k), 32'(trig_out),
                  (k >= 14 && k <= 16) ? 32'd1 : 32'd0);
        end
        trig_in[0] = 1'b0;
        tick(10);
        check("basic_fall_ignored", 32'(trig_out), 32'd0);

        // ---------------- 2: queue of 4, overflow, full-with-pop ----------------
        cfg_write(0, REG_CTRL, 32'h0000_000C);
        cfg_write(0, REG_DELAY, 32'd100);
        for (int k = 0; k <= 210; k++) begin
            exp_bit = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (k >= 101 + 20*j && k <= 103 + 20*j) exp_bit = 1'b1;
            end
            if (k >= 201 && k <= 203) exp_bit = 1'b1;
            check($sformatf("queue_out_k%0d", k), 32'(trig_out[0]), 32'(exp_bit));
            check($sformatf("queue_ovf_k%0d", k), 32'(ovf[0]), (k >= 71) ? 32'd1 : 32'd0);
            soft_trig[0] = (k == 0 || k == 20 || k == 40 || k == 60 || k == 70 || k == 100);
            tick(1);
        end
        soft_trig[0] = 1'b0;
        cfg_read(0, REG_STATUS, rd);
        check("queue_status", rd, 32'h0001_0006);
        cfg_write(0, REG_CTRL, 32'h0000_0014);
        tick(1);
        check("ovf_cleared", 32'(ovf), 32'd0);

        // ---------------- 3: zero delay/width, EDGE=none, disabled ----------------
        cfg_write(0, REG_DELAY, 32'd0);
        cfg_write(0, REG_WIDTH, 32'd0);
        for (int k = 0; k <= 4; k++) begin
            check($sformatf("zero_k%0d", k), 32'(trig_out[0]), (k == 1) ? 32'd1 : 32'd0);
            soft_trig[0] = (k == 0);
            tick(1);
        end
        soft_trig[0] = 1'b0;
        cfg_write(0, REG_CTRL, 32'h0000_0007);
        for (int k = 0; k < 30; k++) begin
            trig_in[0] = ((k / 4) % 2) == 1;
            tick(1);
            check($sformatf("edge_none_k%0d", k), 32'(trig_out), 32'd0);
        end
        trig_in[0] = 1'b0;
        cfg_write(0, REG_CTRL, 32'h0000_0008);
        soft_trig[0] = 1'b1;
        tick(1);
        soft_trig[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check($sformatf("disabled_k%0d", k), 32'(trig_out), 32'd0);
        end
        cfg_read(0, REG_STATUS, rd);
        check("disabled_count", rd, 32'h0000_0001);

        // ---------------- 4: merged pulse ----------------
        cfg_write(0, REG_CTRL, 32'h0000_0004);
        cfg_write(0, REG_DELAY, 32'd5);
        cfg_write(0, REG_WIDTH, 32'd10);
        for (int k = 0; k < 25; k++) begin
            check($sformatf("merge_k%0d", k), 32'(trig_out[0]),
                  (k >= 6 && k <= 19) ? 32'd1 : 32'd0);
            soft_trig[0] = (k == 0 || k == 4);
            tick(1);
        end
        soft_trig[0] = 1'b0;

        // ---------------- 5a: DELAY write flushes pending entries ----------------
        cfg_write(0, REG_DELAY, 32'd50);
        cfg_write(0, REG_WIDTH, 32'd2);
        for (int k = 0; k < 8; k++) begin
            soft_trig[0] = (k == 0 || k == 5);
            tick(1);
        end
        soft_trig[0] = 1'b0;
        cfg_read(0, REG_STATUS, rd);
        check("flush_occ_before", (rd >> 20) & 32'hF, 32'd2);
        cfg_write(0, REG_DELAY, 32'd60);
        for (int k = 0; k < 80; k++) begin
            tick(1);
            check($sformatf("flush_k%0d", k), 32'(trig_out[0]), 32'd0);
        end
        cfg_read(0, REG_STATUS, rd);
        check("flush_occ_after", (rd >> 20) & 32'hF, 32'd0);

        // ---------------- 5b: reset mid-pulse ----------------
        cfg_write(0, REG_DELAY, 32'd0);
        cfg_write(0, REG_WIDTH, 32'd20);
        soft_trig[0] = 1'b1;
        tick(1);
        soft_trig[0] = 1'b0;
        tick(2);
        check("pulse_before_reset", 32'(trig_out[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_kills_pulse", 32'(trig_out), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_rvalid", 32'(cfg_rvalid), 32'd0);
        tick(2);
        rst_n    = 1'b1;
        tb_cycle = 0;
        check("after_reset_out", 32'(trig_out), 32'd0);
        cfg_read(0, REG_DELAY, rd);
        check("after_reset_delay", rd, 32'd0);
        cfg_read(0, REG_WIDTH, rd);
        check("after_reset_width", rd, 32'd1);
        cfg_read(0, REG_CTRL, rd);
        check("after_reset_ctrl", rd, 32'h4);
        cfg_read(0, REG_STATUS, rd);
        check("after_reset_status", rd, 32'd0);

        // ---------------- 6: LAST_TS ----------------
        cfg_write(2, REG_DELAY, 32'd7);
        ts0 = tb_cycle;
        soft_trig[2] = 1'b1;
        tick(1);
        soft_trig[2] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("ts_pulse_k%0d", k), 32'(trig_out), (k == 8) ? 32'h4 : 32'd0);
            tick(1);
        end
        cfg_read(2, REG_LAST_TS, rd);
`ifdef TRIG_DELAY_TIMESTAMP_EN
        check("last_ts", rd, 32'(ts0 + 8));
`else
        check("last_ts", rd, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
